// File: rtl/fb_scanout_pkg.sv
// Shared types and width helpers for the framebuffer scan-out reader.
package fb_scanout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_resp_fifo.sv
// First-word-fall-through response buffer; the write side has no ready,
// so the producer must guarantee space (the scan-out credit count does).
module fb_resp_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A write into a full buffer is only safe when the head leaves this cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (!(wr_en && full && !rd_en)) else $error("scanout buffer overflow");
    end
  end
`endif

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out: fetches one frame per start pulse from a word-addressed
// read port and streams it as AXI4-Stream video (tuser = SOF, tlast = EOL).
module fb_scanout_reader
  import fb_scanout_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 32,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int LINE_STRIDE = 640,
  parameter int BUF_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_resp_valid,
  input  logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int XW = cnt_w(H_RES);
  localparam int YW = cnt_w(V_RES);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  localparam logic [XW-1:0]         X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(V_RES - 1);
  localparam logic [CW-1:0]         CRED_MAX = CW'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(LINE_STRIDE);

  state_t                state;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [XW-1:0]         x_req;
  logic [YW-1:0]         y_req;
  logic [XW-1:0]         x_out;
  logic [YW-1:0]         y_out;
  logic [CW-1:0]         credits;
  logic                  req_hs;
  logic                  out_hs;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign busy          = (state != IDLE);
  // Credits count every request not yet emitted, so the buffer can never overflow.
  assign rd_req_valid  = (state == RUN) && (credits < CRED_MAX);
  assign rd_req_addr   = line_base + ADDR_WIDTH'(x_req);
  assign req_hs        = rd_req_valid && rd_req_ready;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head;
  assign m_axis_tuser  = !fifo_empty && (x_out == '0) && (y_out == '0);
  assign m_axis_tlast  = !fifo_empty && (x_out == X_LAST);
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  fb_resp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_resp_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (rd_resp_valid && busy),
    .wr_data(rd_resp_data),
    .rd_en  (out_hs),
    .rd_data(fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      line_base  <= '0;
      x_req      <= '0;
      y_req      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      credits    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            line_base <= base_addr;
            x_req     <= '0;
            y_req     <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (req_hs) begin
            if (x_req == X_LAST) begin
              x_req     <= '0;
              line_base <= line_base + STRIDE;
              if (y_req == Y_LAST) begin
                y_req <= '0;
                state <= DRAIN;
              end else begin
                y_req <= y_req + 1'b1;
              end
            end else begin
              x_req <= x_req + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_hs && (x_out == X_LAST) && (y_out == Y_LAST)) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      case ({req_hs, out_hs})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase

      if (out_hs) begin
        if (x_out == X_LAST) begin
          x_out <= '0;
          y_out <= (y_out == Y_LAST) ? '0 : y_out + 1'b1;
        end else begin
          x_out <= x_out + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader: 4x2 frame, stride 16, 4-entry buffer,
// memory model with fixed 3-cycle read latency.
module tb_fb_scanout_reader;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
    logic        u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy;
  logic        frame_done;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_resp_valid;
  logic [23:0] rd_resp_data;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fb_scanout_reader #(
    .DATA_WIDTH (24),
    .ADDR_WIDTH (32),
    .H_RES      (4),
    .V_RES      (2),
    .LINE_STRIDE(16),
    .BUF_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .busy         (busy),
    .frame_done   (frame_done),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser)
  );

  function automatic logic [23:0] pix(input logic [31:0] a);
    return a[23:0] ^ 24'hC30000;
  endfunction

  // Memory: every accepted request answers exactly three clocks later.
  logic [2:0]  p_vld = 3'b000;
  logic [31:0] p_addr [3];
  always @(posedge clk) begin
    p_vld     <= {p_vld[1:0], rd_req_valid && rd_req_ready};
    p_addr[0] <= rd_req_addr;
    p_addr[1] <= p_addr[0];
    p_addr[2] <= p_addr[1];
  end
  assign rd_resp_valid = p_vld[2];
  assign rd_resp_data  = pix(p_addr[2]);

  logic [31:0] req_q [$];
  beat_t       beat_q [$];
  int          cyc = 0, done_cnt = 0, done_cyc = -10, last_cyc = 0;
  int          stall_cnt = 0, stall_viol = 0;
  logic        done_busy = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst === 1'b1) begin
      if (rd_req_valid && rd_req_ready) req_q.push_back(rd_req_addr);
      if (m_axis_tvalid && m_axis_tready) begin
        beat_q.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser});
        last_cyc <= cyc;
      end
      if (frame_done) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_busy <= busy;
      end
      if (prev_stall && (!rd_req_valid || rd_req_addr != prev_addr)) stall_viol <= stall_viol + 1;
      if (rd_req_valid && !rd_req_ready) stall_cnt <= stall_cnt + 1;
    end
    prev_stall <= (rst === 1'b1) && rd_req_valid && !rd_req_ready;
    prev_addr  <= rd_req_addr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_a [8];
  int          done0;
  logic        tgl = 1'b0;

  task automatic load_exp(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
    exp_a[4] = a4; exp_a[5] = a5; exp_a[6] = a6; exp_a[7] = a7;
  endtask

  task automatic start_frame(input logic [31:0] base);
    @(negedge clk);
    req_q.delete();
    beat_q.delete();
    done0     = done_cnt;
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == done0 && k < 300) begin
      @(negedge clk);
      if (tgl) rd_req_ready = ~rd_req_ready;
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != done0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
    check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
    check({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_nreq"}, 64'(req_q.size()), 64'd8);
    check({tag, "_nbeat"}, 64'(beat_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < req_q.size())
        check($sformatf("%s_addr%0d", tag, i), 64'(req_q[i]), 64'(exp_a[i]));
      if (i < beat_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), 64'(beat_q[i].d), 64'(pix(exp_a[i])));
        check($sformatf("%s_user%0d", tag, i), 64'(beat_q[i].u), 64'(i == 0));
        check($sformatf("%s_last%0d", tag, i), 64'(beat_q[i].l), 64'(i % 4 == 3));
      end
    end
  endtask

  initial begin
    int s0;
    rst = 1'b0; start = 1'b0; base_addr = '0;
    rd_req_ready = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_reqv", 64'(rd_req_valid), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tuser", 64'(m_axis_tuser), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // 1: basic frame
    load_exp(32'h100, 32'h101, 32'h102, 32'h103, 32'h110, 32'h111, 32'h112, 32'h113);
    start_frame(32'h100);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_first_reqv", 64'(rd_req_valid), 64'd1);
    check("s1_first_addr", 64'(rd_req_addr), 64'h100);
    wait_done("s1");
    check_frame("s1");

    // 2: sink stalled from the start
    load_exp(32'h200, 32'h201, 32'h202, 32'h203, 32'h210, 32'h211, 32'h212, 32'h213);
    m_axis_tready = 1'b0;
    start_frame(32'h200);
    repeat (20) @(negedge clk);
    check("s2_nreq_stalled", 64'(req_q.size()), 64'd4);
    check("s2_reqv_low", 64'(rd_req_valid), 64'd0);
    check("s2_tvalid_held", 64'(m_axis_tvalid), 64'd1);
    check("s2_tuser_held", 64'(m_axis_tuser), 64'd1);
    check("s2_tdata_held", 64'(m_axis_tdata), 64'(pix(32'h200)));
    m_axis_tready = 1'b1;
    wait_done("s2");
    check_frame("s2");

    // 3: request port toggling
    load_exp(32'h100, 32'h101, 32'h102, 32'h103, 32'h110, 32'h111, 32'h112, 32'h113);
    s0 = stall_cnt;
    rd_req_ready = 1'b0;
    tgl = 1'b1;
    start_frame(32'h100);
    wait_done("s3");
    tgl = 1'b0;
    rd_req_ready = 1'b1;
    check("s3_stalls_seen", 64'(stall_cnt > s0), 64'd1);
    check("s3_addr_stable", 64'(stall_viol), 64'd0);
    check_frame("s3");

    // 4: simultaneous request and output handshake at credits 3
    load_exp(32'h40, 32'h41, 32'h42, 32'h43, 32'h50, 32'h51, 32'h52, 32'h53);
    m_axis_tready = 1'b0;
    rd_req_ready  = 1'b0;
    start_frame(32'h40);
    rd_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    rd_req_ready = 1'b0;
    check("s4_three_req", 64'(req_q.size()), 64'd3);
    repeat (6) @(negedge clk);
    check("s4_reqv_at3", 64'(rd_req_valid), 64'd1);
    check("s4_tvalid_at3", 64'(m_axis_tvalid), 64'd1);
    rd_req_ready = 1'b1; m_axis_tready = 1'b1;
    @(negedge clk);
    rd_req_ready = 1'b0; m_axis_tready = 1'b0;
    check("s4_nreq_both", 64'(req_q.size()), 64'd4);
    check("s4_nbeat_both", 64'(beat_q.size()), 64'd1);
    check("s4_reqv_after", 64'(rd_req_valid), 64'd1);
    rd_req_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("s4_one_more_req", 64'(req_q.size()), 64'd5);
    check("s4_reqv_full", 64'(rd_req_valid), 64'd0);
    m_axis_tready = 1'b1;
    wait_done("s4");
    check_frame("s4");

    // 5a: start mid-frame is ignored
    load_exp(32'h300, 32'h301, 32'h302, 32'h303, 32'h310, 32'h311, 32'h312, 32'h313);
    start_frame(32'h300);
    repeat (3) @(negedge clk);
    start = 1'b1; base_addr = 32'h999;
    @(negedge clk);
    start = 1'b0;
    wait_done("s5a");
    check_frame("s5a");

    // 5b: reset mid-frame, late responses dropped
    start_frame(32'h400);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s5b_busy", 64'(busy), 64'd0);
    check("s5b_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("s5b_reqv", 64'(rd_req_valid), 64'd0);
    rst = 1'b1;
    s0 = beat_q.size();
    repeat (6) @(negedge clk);
    check("s5b_late_dropped", 64'(m_axis_tvalid), 64'd0);
    check("s5b_no_beats", 64'(beat_q.size() - s0), 64'd0);
    check("s5b_no_done", 64'(done_cnt - done0), 64'd0);

    // 5c: restart after reset
    load_exp(32'h500, 32'h501, 32'h502, 32'h503, 32'h510, 32'h511, 32'h512, 32'h513);
    start_frame(32'h500);
    wait_done("s5c");
    check_frame("s5c");

    // 6: address wrap
    load_exp(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'hE, 32'hF, 32'h10, 32'h11);
    start_frame(32'hFFFF_FFFE);
    wait_done("s6");
    check_frame("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
